csa_operand_sequencer: RTL and testbench

Sequential front/back end for the 10-operand, 8-bit carry-save adder (`csa`). It accepts operands one byte per handshake, holds all ten on registered outputs that drive the adder's `a`..`j` inputs, and waits one settle cycle for the combinational CSA tree. It then captures the adder's 18-bit `s` result and presents it on a valid/ready output port. An internal running reference sum is checked against the adder result, and any difference raises an error flag.

---
 rtl/csa_operand_sequencer.sv | 127 ++++++++++++
 tb/tb_csa_operand_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_operand_sequencer.sv
// Operand loader and result capture wrapped around the 10-operand carry-save adder.
// Loads ten bytes, waits one settle cycle, captures the sum, and checks it against a running reference.
module csa_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int SUM_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] op_c,
    output logic [WIDTH-1:0] op_d,
    output logic [WIDTH-1:0] op_e,
    output logic [WIDTH-1:0] op_f,
    output logic [WIDTH-1:0] op_g,
    output logic [WIDTH-1:0] op_h,
    output logic [WIDTH-1:0] op_i,
    output logic [WIDTH-1:0] op_j,
    input  logic [SUM_W-1:0] csa_sum,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_sum,
    input  logic             out_ready,
    output logic             sum_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        HOLD
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] ops [10];
    logic [SUM_W-1:0] ref_sum;
    logic             accept;
    logic             do_abort;
    logic             capture;
    logic             release_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    // Abort takes priority over a same-cycle accept; the byte is dropped.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        do_abort    = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            LOAD: begin
                if (abort) begin
                    do_abort = 1'b1;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == 4'd9) next_state = SETTLE;
                end
            end
            SETTLE: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    next_state  = LOAD;
                end
            end
            default: next_state = LOAD;
        endcase
    end

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD) || (cnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ref_sum   <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            sum_err   <= 1'b0;
            for (int unsigned i = 0; i < 10; i++) ops[i] <= '0;
        end else begin
            if (do_abort) begin
                cnt     <= '0;
                ref_sum <= '0;
            end else if (accept) begin
                for (int unsigned i = 0; i < 10; i++) begin
                    if (cnt == 4'(i)) ops[i] <= in_data;
                end
                ref_sum <= ref_sum + SUM_W'(in_data);
                cnt     <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
            end
            if (capture) begin
                out_sum   <= csa_sum;
                sum_err   <= (csa_sum != ref_sum);
                out_valid <= 1'b1;
            end
            if (release_out) begin
                out_valid <= 1'b0;
                ref_sum   <= '0;
            end
        end
    end

    assign op_a = ops[0];
    assign op_b = ops[1];
    assign op_c = ops[2];
    assign op_d = ops[3];
    assign op_e = ops[4];
    assign op_f = ops[5];
    assign op_g = ops[6];
    assign op_h = ops[7];
    assign op_i = ops[8];
    assign op_j = ops[9];

endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Self-checking bench for csa_operand_sequencer; the bench also stands in for the csa adder.
`timescale 1ns/1ps
module tb_csa_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        abort = 1'b0;
    logic [7:0]  op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, op_i, op_j;
    logic [17:0] csa_sum;
    logic        out_valid;
    logic [17:0] out_sum;
    logic        out_ready = 1'b0;
    logic        sum_err;
    logic        busy;

    logic        force_en = 1'b0;
    logic [17:0] force_val = '0;
    logic [17:0] csa_model;
    logic [7:0]  op_w [10];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    csa_operand_sequencer #(.WIDTH(8), .SUM_W(18)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .abort(abort),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_e(op_e),
        .op_f(op_f), .op_g(op_g), .op_h(op_h), .op_i(op_i), .op_j(op_j),
        .csa_sum(csa_sum), .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready),
        .sum_err(sum_err), .busy(busy)
    );

    assign op_w = '{op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h, op_i, op_j};
    assign csa_model = 18'(op_a) + 18'(op_b) + 18'(op_c) + 18'(op_d) + 18'(op_e)
                     + 18'(op_f) + 18'(op_g) + 18'(op_h) + 18'(op_i) + 18'(op_j);
    assign csa_sum = force_en ? force_val : csa_model;

    typedef struct {
        logic [7:0]  b [10];
        bit          frc;
        logic [17:0] fval;
        int          bp;
        bit          gaps;
        logic [17:0] exp_sum;
        bit          exp_err;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [17:0] model_sum(input logic [7:0] b [10]);
        logic [17:0] s = '0;
        for (int i = 0; i < 10; i++) s += 18'(b[i]);
        return s;
    endfunction

    task automatic run_frame(input logic [7:0] b [10], input bit frc, input logic [17:0] fval,
                             input int bp, input bit gaps, input logic [17:0] exp_sum,
                             input bit exp_err);
        force_en  = frc;
        force_val = fval;
        for (int i = 0; i < 10; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(b[i]);
            if (i == 0) chk("busy_loading", 32'(busy), 32'd1);
        end
        chk("settle_out_valid", 32'(out_valid), 32'd0);
        chk("settle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("out_sum", 32'(out_sum), 32'(exp_sum));
        chk("sum_err", 32'(sum_err), 32'(exp_err));
        for (int i = 0; i < 10; i++) chk("op_value", 32'(op_w[i]), 32'(b[i]));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum", 32'(out_sum), 32'(exp_sum));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        if (bp > 0) for (int i = 0; i < 10; i++) chk("bp_op_stable", 32'(op_w[i]), 32'(b[i]));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_sum_err_held", 32'(sum_err), 32'(exp_err));
        force_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rb [10];
        logic [17:0] s;
        bit f;
        logic [17:0] fv;

        tbl[0].b = '{8'd11, 8'd2, 8'd13, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        tbl[0].frc = 0; tbl[0].fval = '0; tbl[0].bp = 0; tbl[0].gaps = 0;
        tbl[0].exp_sum = 18'd75; tbl[0].exp_err = 0;
        tbl[1].b = '{8'd3, 8'd14, 8'd5, 8'd6, 8'd7, 8'd8, 8'd19, 8'd10, 8'd0, 8'd0};
        tbl[1].frc = 0; tbl[1].fval = '0; tbl[1].bp = 0; tbl[1].gaps = 0;
        tbl[1].exp_sum = 18'd72; tbl[1].exp_err = 0;
        tbl[2].b = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd254};
        tbl[2].frc = 0; tbl[2].fval = '0; tbl[2].bp = 5; tbl[2].gaps = 0;
        tbl[2].exp_sum = 18'h009F5; tbl[2].exp_err = 0;
        tbl[3].b = tbl[0].b;
        tbl[3].frc = 1; tbl[3].fval = 18'd76; tbl[3].bp = 2; tbl[3].gaps = 0;
        tbl[3].exp_sum = 18'd76; tbl[3].exp_err = 1;
        tbl[4].b = tbl[1].b;
        tbl[4].frc = 0; tbl[4].fval = '0; tbl[4].bp = 1; tbl[4].gaps = 1;
        tbl[4].exp_sum = 18'd72; tbl[4].exp_err = 0;

        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_op_a", 32'(op_a), 32'd0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++)
            run_frame(tbl[t].b, tbl[t].frc, tbl[t].fval, tbl[t].bp, tbl[t].gaps,
                      tbl[t].exp_sum, tbl[t].exp_err);

        // abort after four bytes, together with a valid byte that must be dropped
        for (int i = 0; i < 4; i++) send_byte(8'd50);
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        @(posedge clk);
        #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) rb[i] = 8'd1;
        run_frame(rb, 0, '0, 0, 0, 18'd10, 0);

        // error frame, then reset asserted during SETTLE
        run_frame(tbl[3].b, 1, 18'd76, 0, 0, 18'd76, 1);
        for (int i = 0; i < 10; i++) send_byte(8'd200);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_op_j", 32'(op_j), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum_err", 32'(sum_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(tbl[0].b, 0, '0, 0, 0, 18'd75, 0);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 10; i++) rb[i] = 8'($urandom);
            s  = model_sum(rb);
            f  = ($urandom_range(0, 3) == 0);
            fv = s + 18'($urandom_range(1, 100));
            run_frame(rb, f, fv, $urandom_range(0, 3), 1, f ? fv : s, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
